// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, multiply/divide opcodes and FSM state encoding
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_OR   = 4'd2,
    OP_AND  = 4'd3,
    OP_SLTU = 4'd4,
    OP_NOR  = 4'd5,
    OP_XOR  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10
  } alu_op_e;
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;
endpackage

// File: rtl/md_iter.sv
// md_iter: iterative shift-add multiplier and restoring divider with hi/lo result registers
module md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic [1:0]       mdop,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_e             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_l, b_l, a_mag, d, q, r, res_hi, res_lo;
  logic [1:0]         op_l;
  logic [2*WIDTH-1:0] p, p_nx, prod;
  logic [WIDTH:0]     acc, t, diff;
  logic               sgn, is_div, neg_q, neg_r;
  // Both multiply and divide start from {0, |A|}: multiplier bits shift out the bottom, dividend bits shift out the top.
  assign a_mag = (!mdop[0] && a[WIDTH-1]) ? -a : a;
  always_comb begin
    sgn    = !op_l[0];
    is_div = op_l[1];
    d      = (sgn && b_l[WIDTH-1]) ? -b_l : b_l;
    acc    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, d} : {(WIDTH+1){1'b0}});
    t      = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    diff   = t - {1'b0, d};
    p_nx   = !is_div ? {acc, p[WIDTH-1:1]} :
             diff[WIDTH] ? {t[WIDTH-1:0], p[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    neg_q  = sgn && (a_l[WIDTH-1] ^ b_l[WIDTH-1]);
    neg_r  = sgn && a_l[WIDTH-1];
    prod   = neg_q ? -p_nx : p_nx;
    q      = p_nx[WIDTH-1:0];
    r      = p_nx[2*WIDTH-1:WIDTH];
    res_lo = !is_div ? prod[WIDTH-1:0] : (b_l == '0) ? {WIDTH{1'b1}} : neg_q ? -q : q;
    res_hi = !is_div ? prod[2*WIDTH-1:WIDTH] : neg_r ? -r : r;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_l   <= '0;
      b_l   <= '0;
      op_l  <= '0;
      p     <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == S_RUN) begin
      p   <= p_nx;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH-1)) begin
        state <= S_FIN;
        cnt   <= '0;
        hi    <= res_hi;
        lo    <= res_lo;
      end
    end else if (start) begin
      state <= S_RUN;
      cnt   <= '0;
      a_l   <= a;
      b_l   <= b;
      op_l  <= mdop;
      p     <= {{WIDTH{1'b0}}, a_mag};
    end else begin
      state <= S_IDLE;
      if (hi_we) hi <= a;
      if (lo_we) lo <= a;
    end
  end
  assign busy = (state == S_RUN);
  assign done = (state == S_FIN);
endmodule

// File: rtl/alu_md.sv
// alu_md: combinational ALU alongside an iterative multiply/divide unit
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  output logic             Zero,
  output logic             Overflow,
  input  logic             start,
  input  logic [1:0]       mdop,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH-1:0] add, sub;
  logic [SW-1:0]    sh;
  assign add = A + B;
  assign sub = A - B;
  assign sh  = B[SW-1:0];
  always_comb begin
    case (ALUOp)
      OP_ADD:  C = add;
      OP_SUB:  C = sub;
      OP_OR:   C = A | B;
      OP_AND:  C = A & B;
      OP_SLTU: C = {{(WIDTH-1){1'b0}}, A < B};
      OP_NOR:  C = ~(A | B);
      OP_XOR:  C = A ^ B;
      OP_SLT:  C = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLL:  C = A << sh;
      OP_SRL:  C = A >> sh;
      OP_SRA:  C = $unsigned($signed(A) >>> sh);
      default: C = '0;
    endcase
  end
  assign Zero     = (C == '0);
  assign Overflow = (ALUOp == OP_ADD) ? (A[WIDTH-1] == B[WIDTH-1]) && (add[WIDTH-1] != A[WIDTH-1]) :
                    (ALUOp == OP_SUB) ? (A[WIDTH-1] != B[WIDTH-1]) && (sub[WIDTH-1] != A[WIDTH-1]) : 1'b0;
  md_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst   (rst),
    .a     (A),
    .b     (B),
    .start (start),
    .mdop  (mdop),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: scoreboard bench for alu_md at WIDTH=32
module tb_alu_md;
  import alu_pkg::*;
  logic        clk = 0, rst = 1, start = 0, hi_we = 0, lo_we = 0;
  logic [31:0] A = 0, B = 0;
  logic [3:0]  ALUOp = 0;
  logic [1:0]  mdop = 0;
  logic [31:0] C, hi, lo;
  logic        Zero, Overflow, busy, done;
  int errors = 0, checks = 0;
  typedef struct packed {logic [31:0] hi, lo;} res_t;
  typedef struct {logic [1:0] op; logic [31:0] a, b;} md_vec_t;
  typedef struct {logic [3:0] op; logic [31:0] a, b, c; logic ov, z;} alu_vec_t;
  res_t sb[$];
  res_t last;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALUOp(ALUOp), .C(C), .Zero(Zero), .Overflow(Overflow),
    .start(start), .mdop(mdop), .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic res_t model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] up;
    res_t r;
    if (op == MD_MULT) begin
      sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      r = sp;
    end else if (op == MD_MULTU) begin
      up = {32'b0, a} * {32'b0, b};
      r = up;
    end else if (b == 0) r = {a, 32'hFFFFFFFF};
    else if (op == MD_DIVU) r = {a % b, a / b};
    else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
    else r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return r;
  endfunction

  task automatic start_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a; B = b; mdop = op; start = 1;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_flags: busy/done=%b expected 00", {busy, done}); end
    checks++;
    if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: hi=%h lo=%h expected 0", hi, lo); end
    checks++;
    if ({C, Zero} !== {32'h0, 1'b1}) begin errors++; $display("FAIL reset_alu: C=%h Zero=%b expected 0/1", C, Zero); end
  endtask

  task automatic test_alu();
    alu_vec_t v[15];
    v[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 0};
    v[1]  = '{OP_SUB,  32'd5,        32'd5,        32'h0,        0, 1};
    v[2]  = '{OP_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1, 0};
    v[3]  = '{OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        0, 1};
    v[4]  = '{OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        0, 0};
    v[5]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 1};
    v[6]  = '{OP_SRA,  32'h80000000, 32'h24,       32'hF8000000, 0, 0};
    v[7]  = '{OP_SLL,  32'h1,        32'h23,       32'h8,        0, 0};
    v[8]  = '{OP_SRL,  32'h80000000, 32'd31,       32'h1,        0, 0};
    v[9]  = '{OP_OR,   32'hF0F0,     32'h0F0F,     32'hFFFF,     0, 0};
    v[10] = '{OP_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0, 0};
    v[11] = '{OP_NOR,  32'h0,        32'h0,        32'hFFFFFFFF, 0, 0};
    v[12] = '{OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 0, 0};
    v[13] = '{4'd12,   32'd5,        32'd6,        32'h0,        0, 1};
    v[14] = '{OP_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 0};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ALUOp = v[i].op; A = v[i].a; B = v[i].b;
      #1;
      checks++;
      if ({C, Overflow, Zero} !== {v[i].c, v[i].ov, v[i].z})
        begin errors++; $display("FAIL alu[%0d] op=%0d: C=%h ov=%b z=%b expected C=%h ov=%b z=%b", i, v[i].op, C, Overflow, Zero, v[i].c, v[i].ov, v[i].z); end
    end
    ALUOp = 0;
  endtask

  task automatic test_md(input string name, input md_vec_t v[$]);
    int n;
    res_t e;
    foreach (v[i]) begin
      start_md(v[i].op, v[i].a, v[i].b);
      wait_idle(n);
      checks++;
      if (n !== 32) begin errors++; $display("FAIL %s[%0d]_busy_cycles: got %0d expected 32", name, i, n); end
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL %s[%0d]_done: got %b expected 1", name, i, done); end
      e = sb.pop_front();
      last = e;
      checks++;
      if ({hi, lo} !== e) begin errors++; $display("FAIL %s[%0d]_result: hi=%h lo=%h expected hi=%h lo=%h", name, i, hi, lo, e.hi, e.lo); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL %s[%0d]_done_pulse: got %b expected 0", name, i, done); end
    end
  endtask

  task automatic test_mult();
    md_vec_t v[$];
    v.push_back('{MD_MULT,  32'hFFFFFFFD, 32'd7});
    v.push_back('{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF});
    v.push_back('{MD_MULT,  32'h80000000, 32'h80000000});
    v.push_back('{MD_MULTU, 32'h12345678, 32'h9ABCDEF0});
    test_md("mult", v);
    if (last !== {32'h0B00EA4E, 32'h242D2080}) begin checks++; errors++; $display("FAIL multu_const: hi=%h lo=%h expected 0b00ea4e/242d2080", hi, lo); end
  endtask

  task automatic test_div();
    md_vec_t v[$];
    v.push_back('{MD_DIV,  32'hFFFFFFF9, 32'd2});
    v.push_back('{MD_DIVU, 32'd7,        32'd0});
    v.push_back('{MD_DIV,  32'h80000000, 32'hFFFFFFFF});
    v.push_back('{MD_DIV,  32'hFFFFFFF9, 32'd0});
    v.push_back('{MD_DIVU, 32'd100,      32'd7});
    v.push_back('{MD_DIV,  32'd100,      32'hFFFFFFF9});
    test_md("div", v);
  endtask

  task automatic test_ignore();
    int n;
    res_t e;
    start_md(MD_MULT, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    A = 32'hDEAD; B = 32'd1; mdop = MD_DIVU; start = 1; hi_we = 1; lo_we = 1;
    @(negedge clk);
    start = 0; hi_we = 0; lo_we = 0;
    checks++;
    if ({hi, lo} !== last) begin errors++; $display("FAIL ignore_run_hold: hi=%h lo=%h expected %h/%h", hi, lo, last.hi, last.lo); end
    wait_idle(n);
    checks++;
    if (n !== 26) begin errors++; $display("FAIL ignore_busy_cycles: got %0d expected 26", n); end
    e = sb.pop_front();
    last = e;
    checks++;
    if ({done, hi, lo} !== {1'b1, e}) begin errors++; $display("FAIL ignore_result: done=%b hi=%h lo=%h expected 1 %h %h", done, hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_mthi();
    int n;
    res_t e;
    @(negedge clk);
    A = 32'h1234; hi_we = 1;
    @(negedge clk);
    hi_we = 0;
    checks++;
    if ({hi, lo} !== {32'h1234, last.lo}) begin errors++; $display("FAIL mthi: hi=%h lo=%h expected 00001234/%h", hi, lo, last.lo); end
    A = 32'h5678; lo_we = 1;
    @(negedge clk);
    lo_we = 0;
    checks++;
    if ({hi, lo} !== {32'h1234, 32'h5678}) begin errors++; $display("FAIL mtlo: hi=%h lo=%h expected 00001234/00005678", hi, lo); end
    A = 32'd2; B = 32'd3; mdop = MD_MULTU; start = 1; hi_we = 1;
    sb.push_back(model(MD_MULTU, 32'd2, 32'd3));
    @(negedge clk);
    start = 0; hi_we = 0;
    checks++;
    if ({busy, hi} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL mthi_with_start: busy=%b hi=%h expected 1/00001234", busy, hi); end
    wait_idle(n);
    e = sb.pop_front();
    last = e;
    checks++;
    if ({hi, lo} !== e) begin errors++; $display("FAIL mthi_start_result: hi=%h lo=%h expected %h/%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    res_t e;
    start_md(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    e = sb.pop_front();
    checks++;
    if ({done, hi, lo} !== {1'b1, e}) begin errors++; $display("FAIL b2b_first: done=%b hi=%h lo=%h expected 1 %h %h", done, hi, lo, e.hi, e.lo); end
    A = 32'h80000000; B = 32'hFFFFFFFF; mdop = MD_DIV; start = 1;
    sb.push_back(model(MD_DIV, 32'h80000000, 32'hFFFFFFFF));
    @(negedge clk);
    start = 0;
    wait_idle(n);
    checks++;
    if (n !== 32) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 32", n); end
    e = sb.pop_front();
    last = e;
    checks++;
    if ({done, hi, lo} !== {1'b1, e}) begin errors++; $display("FAIL b2b_second: done=%b hi=%h lo=%h expected 1 %h %h", done, hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    A = 32'hFFFFFFFD; B = 32'd7; mdop = MD_MULT; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    rst = 1; start = 1; hi_we = 1; lo_we = 1; A = 32'hABCD;
    @(negedge clk);
    rst = 0; start = 0; hi_we = 0; lo_we = 0;
    checks++;
    if ({busy, done, hi, lo} !== 66'h0) begin errors++; $display("FAIL abort_state: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= done | busy;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: saw busy/done=%b expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_ignore();
    test_mthi();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
